// File: rtl/timer_irq_master.sv
// ----------------------------------------------------------------------------
// timer_irq_master
//
// Wishbone initiator that services the periodic timer interrupt. A pending
// interrupt triggers a single read to the timer's acknowledge address. The
// block then waits for the interrupt line to fall, counts the serviced tick,
// and re-issues the read or raises a sticky fault when the responder
// misbehaves (error termination, no termination, or an interrupt that never
// drops).
//
// Ports
//   CLK_I        in   clock, rising edge
//   RST_N_I      in   asynchronous active-low reset
//   enable_i     in   arms servicing (looked at in IDLE only)
//   clear_i      in   one-cycle pulse that releases the HOLD state
//   interrupt_i  in   level interrupt from the timer
//   ADR_O[29:0]  out  word address (byte address bits 31:2)
//   CYC_O/STB_O  out  bus cycle / strobe
//   WE_O         out  write enable, always 0
//   ACK_I/RTY_I  in   normal / retry termination (both count as acknowledge)
//   ERR_I        in   error termination
//   tick_count   out  serviced interrupts, wraps at 16 bits
//   tick_pulse   out  one-cycle pulse per serviced interrupt
//   bus_error    out  sticky fault flag
//   timeout_o    out  sticky, fault was caused by a bus timeout
//   attempts     out  bus cycles issued for the current/last interrupt
// ----------------------------------------------------------------------------
module timer_irq_master #(
   parameter logic [29:0] ACK_ADDR   = 30'h3FFFFFF9,
   parameter int          TIMEOUT    = 15,
   parameter int          SETTLE_CYC = 4,
   parameter int          MAX_RETRY  = 3
) (
   input  logic        CLK_I,
   input  logic        RST_N_I,
   input  logic        enable_i,
   input  logic        clear_i,
   input  logic        interrupt_i,
   output logic [29:0] ADR_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   input  logic        RTY_I,
   input  logic        ERR_I,
   output logic [15:0] tick_count,
   output logic        tick_pulse,
   output logic        bus_error,
   output logic        timeout_o,
   output logic [3:0]  attempts
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_SETTLE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [7:0] SETTLE_C  = 8'(SETTLE_CYC);
   localparam logic [4:0] RETRY_C   = 5'(MAX_RETRY);

   state_t      state_reg, state_next;
   logic [7:0]  wait_cnt_reg, wait_cnt_next;
   // One bit wider than the attempts port so MAX_RETRY=15 still terminates.
   logic [4:0]  att_cnt_reg, att_cnt_next;
   logic [29:0] adr_reg, adr_next;
   logic        cyc_reg, cyc_next;
   logic        we_reg;
   logic [15:0] tick_cnt_reg, tick_cnt_next;
   logic        tick_pulse_reg, tick_pulse_next;
   logic        bus_error_reg, bus_error_next;
   logic        timeout_reg, timeout_next;
   logic [3:0]  attempts_reg, attempts_next;

   logic [7:0]  wait_inc;
   logic        term_ok;
   logic        settled;

   assign wait_inc = wait_cnt_reg + 8'd1;
   assign term_ok  = ACK_I | RTY_I;
   assign settled  = (state_reg == S_SETTLE) && !interrupt_i;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_reg      <= S_IDLE;
         wait_cnt_reg   <= 8'd0;
         att_cnt_reg    <= 5'd0;
         adr_reg        <= 30'd0;
         cyc_reg        <= 1'b0;
         we_reg         <= 1'b0;
         tick_cnt_reg   <= 16'd0;
         tick_pulse_reg <= 1'b0;
         bus_error_reg  <= 1'b0;
         timeout_reg    <= 1'b0;
         attempts_reg   <= 4'd0;
      end else begin
         state_reg      <= state_next;
         wait_cnt_reg   <= wait_cnt_next;
         att_cnt_reg    <= att_cnt_next;
         adr_reg        <= adr_next;
         cyc_reg        <= cyc_next;
         we_reg         <= 1'b0;
         tick_cnt_reg   <= tick_cnt_next;
         tick_pulse_reg <= tick_pulse_next;
         bus_error_reg  <= bus_error_next;
         timeout_reg    <= timeout_next;
         attempts_reg   <= attempts_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (enable_i && interrupt_i)
               state_next = S_REQ;
         end
         S_REQ: begin
            // Error outranks a simultaneous acknowledge.
            if (ERR_I)
               state_next = S_HOLD;
            else if (term_ok)
               state_next = S_SETTLE;
            else if (wait_inc == TIMEOUT_C)
               state_next = S_HOLD;
         end
         S_SETTLE: begin
            if (!interrupt_i)
               state_next = S_IDLE;
            else if (wait_inc == SETTLE_C)
               state_next = (att_cnt_reg <= RETRY_C) ? S_REQ : S_HOLD;
         end
         S_HOLD: begin
            if (clear_i)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath next values. Bus outputs follow the next state so
   // they are registered yet change on the same edge as the state.
   // ------------------------------------------------------------------
   always_comb begin
      cyc_next        = (state_next == S_REQ);
      adr_next        = cyc_next ? ACK_ADDR : 30'd0;
      tick_pulse_next = settled;
      tick_cnt_next   = settled ? tick_cnt_reg + 16'd1 : tick_cnt_reg;

      // Wait counter runs inside REQ/SETTLE and restarts on every state change.
      wait_cnt_next = 8'd0;
      if ((state_next == state_reg) &&
          (state_reg == S_REQ || state_reg == S_SETTLE))
         wait_cnt_next = wait_inc;

      att_cnt_next = att_cnt_reg;
      if (state_reg == S_IDLE && state_next == S_REQ)
         att_cnt_next = 5'd1;
      else if (state_reg == S_SETTLE && state_next == S_REQ)
         att_cnt_next = att_cnt_reg + 5'd1;
      attempts_next = (att_cnt_next > 5'd15) ? 4'hF : att_cnt_next[3:0];

      bus_error_next = bus_error_reg;
      timeout_next   = timeout_reg;
      if (state_reg == S_HOLD && clear_i) begin
         bus_error_next = 1'b0;
         timeout_next   = 1'b0;
      end else if (state_reg != S_HOLD && state_next == S_HOLD) begin
         bus_error_next = 1'b1;
         // Only the no-termination path out of REQ counts as a timeout.
         if (state_reg == S_REQ && !ERR_I)
            timeout_next = 1'b1;
      end
   end

   assign ADR_O      = adr_reg;
   assign CYC_O      = cyc_reg;
   assign STB_O      = cyc_reg;
   assign WE_O       = we_reg;
   assign tick_count = tick_cnt_reg;
   assign tick_pulse = tick_pulse_reg;
   assign bus_error  = bus_error_reg;
   assign timeout_o  = timeout_reg;
   assign attempts   = attempts_reg;

endmodule

// File: tb/tb_timer_irq_master.sv
module tb_timer_irq_master;

   logic        CLK_I = 1'b0;
   logic        RST_N_I;
   logic        enable_i, clear_i, interrupt_i;
   logic [29:0] ADR_O;
   logic        CYC_O, STB_O, WE_O;
   logic        ACK_I, RTY_I, ERR_I;
   logic [15:0] tick_count;
   logic        tick_pulse, bus_error, timeout_o;
   logic [3:0]  attempts;

   int vectors;
   int miscompares;

   always #5 CLK_I = ~CLK_I;

   timer_irq_master dut (
      .CLK_I      (CLK_I),
      .RST_N_I    (RST_N_I),
      .enable_i   (enable_i),
      .clear_i    (clear_i),
      .interrupt_i(interrupt_i),
      .ADR_O      (ADR_O),
      .CYC_O      (CYC_O),
      .STB_O      (STB_O),
      .WE_O       (WE_O),
      .ACK_I      (ACK_I),
      .RTY_I      (RTY_I),
      .ERR_I      (ERR_I),
      .tick_count (tick_count),
      .tick_pulse (tick_pulse),
      .bus_error  (bus_error),
      .timeout_o  (timeout_o),
      .attempts   (attempts)
   );

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic test_reset();
      RST_N_I = 1'b0; enable_i = 1'b0; clear_i = 1'b0; interrupt_i = 1'b0;
      ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;
      #2;
      vectors++;
      if ({ADR_O, CYC_O, STB_O, WE_O} !== 33'd0) begin
         miscompares++;
         $display("FAIL reset_bus: got adr=%h cyc=%b stb=%b we=%b, want all 0", ADR_O, CYC_O, STB_O, WE_O);
      end
      vectors++;
      if ({tick_count, tick_pulse, bus_error, timeout_o, attempts} !== 23'd0) begin
         miscompares++;
         $display("FAIL reset_status: got cnt=%h pulse=%b err=%b to=%b att=%0d, want all 0",
                  tick_count, tick_pulse, bus_error, timeout_o, attempts);
      end
      step(); step();
      RST_N_I = 1'b1;
      step();
      $display("reset released: cnt=%h err=%b", tick_count, bus_error);
   endtask

   task automatic test_basic();
      enable_i = 1'b1; interrupt_i = 1'b1;
      step();
      vectors++;
      if ({CYC_O, STB_O, WE_O, ADR_O} !== {3'b110, 30'h3FFFFFF9}) begin
         miscompares++;
         $display("FAIL basic_req: got cyc=%b stb=%b we=%b adr=%h, want cyc=1 stb=1 we=0 adr=3ffffff9",
                  CYC_O, STB_O, WE_O, ADR_O);
      end
      step();
      vectors++;
      if (CYC_O !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_hold_cyc: got cyc=%b want 1", CYC_O);
      end
      RTY_I = 1'b1; interrupt_i = 1'b0;
      step();
      RTY_I = 1'b0;
      vectors++;
      if ({CYC_O, tick_pulse} !== 2'b00) begin
         miscompares++;
         $display("FAIL basic_settle: got cyc=%b pulse=%b want 0 0", CYC_O, tick_pulse);
      end
      step();
      vectors++;
      if ({tick_pulse, tick_count} !== {1'b1, 16'd1}) begin
         miscompares++;
         $display("FAIL basic_tick: got pulse=%b cnt=%h want pulse=1 cnt=0001", tick_pulse, tick_count);
      end
      step();
      vectors++;
      if ({tick_pulse, tick_count, attempts, bus_error} !== {1'b0, 16'd1, 4'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_after: got pulse=%b cnt=%h att=%0d err=%b want 0 0001 1 0",
                  tick_pulse, tick_count, attempts, bus_error);
      end
      $display("basic service: cnt=%h att=%0d err=%b", tick_count, attempts, bus_error);
   endtask

   task automatic test_sticky();
      int idle_cnt;
      interrupt_i = 1'b1;
      step();
      vectors++;
      if (CYC_O !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_start: got cyc=%b want 1", CYC_O);
      end
      for (int k = 0; k < 4; k++) begin
         ACK_I = 1'b1;
         step();
         ACK_I = 1'b0;
         idle_cnt = (CYC_O === 1'b0) ? 1 : 0;
         for (int j = 0; j < 3; j++) begin
            step();
            if (CYC_O === 1'b0) idle_cnt++;
         end
         vectors++;
         if (idle_cnt != 4) begin
            miscompares++;
            $display("FAIL sticky_gap%0d: got %0d idle cycles want 4", k, idle_cnt);
         end
         step();
         if (k < 3) begin
            vectors++;
            if ({CYC_O, attempts} !== {1'b1, 4'(k + 2)}) begin
               miscompares++;
               $display("FAIL sticky_retry%0d: got cyc=%b att=%0d want cyc=1 att=%0d", k, CYC_O, attempts, k + 2);
            end
         end else begin
            vectors++;
            if ({CYC_O, bus_error, timeout_o, tick_count, attempts} !== {3'b010, 16'd1, 4'd4}) begin
               miscompares++;
               $display("FAIL sticky_hold: got cyc=%b err=%b to=%b cnt=%h att=%0d want 0 1 0 0001 4",
                        CYC_O, bus_error, timeout_o, tick_count, attempts);
            end
         end
      end
      // HOLD must not service a new interrupt by itself.
      step(); step();
      vectors++;
      if ({CYC_O, bus_error} !== 2'b01) begin
         miscompares++;
         $display("FAIL sticky_stays_hold: got cyc=%b err=%b want 0 1", CYC_O, bus_error);
      end
      interrupt_i = 1'b0;
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      vectors++;
      if ({bus_error, timeout_o, tick_count} !== {2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL sticky_clear: got err=%b to=%b cnt=%h want 0 0 0001", bus_error, timeout_o, tick_count);
      end
      $display("sticky interrupt: 4 cycles then hold, cleared err=%b", bus_error);
   endtask

   task automatic test_timeout();
      int hi;
      interrupt_i = 1'b1;
      step();
      enable_i = 1'b0;  // must not abort the ongoing service
      hi = (CYC_O === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (CYC_O !== 1'b1) break;
         hi++;
      end
      vectors++;
      if (hi != 15) begin
         miscompares++;
         $display("FAIL timeout_len: got cyc high %0d cycles want 15", hi);
      end
      vectors++;
      if ({CYC_O, bus_error, timeout_o} !== 3'b011) begin
         miscompares++;
         $display("FAIL timeout_flags: got cyc=%b err=%b to=%b want 0 1 1", CYC_O, bus_error, timeout_o);
      end
      interrupt_i = 1'b0;
      enable_i = 1'b1;
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      vectors++;
      if ({bus_error, timeout_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL timeout_clear: got err=%b to=%b want 0 0", bus_error, timeout_o);
      end
      $display("timeout: cyc high %0d cycles, flags cleared", hi);
   endtask

   task automatic test_err_wins();
      interrupt_i = 1'b1;
      step();
      ERR_I = 1'b1; ACK_I = 1'b1;
      step();
      ERR_I = 1'b0; ACK_I = 1'b0;
      vectors++;
      if ({CYC_O, bus_error, timeout_o, tick_count} !== {3'b010, 16'd1}) begin
         miscompares++;
         $display("FAIL err_wins: got cyc=%b err=%b to=%b cnt=%h want 0 1 0 0001",
                  CYC_O, bus_error, timeout_o, tick_count);
      end
      interrupt_i = 1'b0;
      step();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      vectors++;
      if (bus_error !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear: got err=%b want 0", bus_error);
      end
      $display("err+ack: error wins, cnt=%h", tick_count);
   endtask

   task automatic test_back_to_back();
      // Bring the counter from 1 to FFFF with back-to-back services.
      for (int n = 0; n < 65534; n++) begin
         interrupt_i = 1'b1;
         step();
         ACK_I = 1'b1; interrupt_i = 1'b0;
         step();
         ACK_I = 1'b0;
         step();
      end
      vectors++;
      if (tick_count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_preload: got cnt=%h want ffff", tick_count);
      end
      interrupt_i = 1'b1;
      step();
      vectors++;
      if (CYC_O !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_latency: got cyc=%b want 1", CYC_O);
      end
      ACK_I = 1'b1; interrupt_i = 1'b0;
      step();
      ACK_I = 1'b0;
      step();
      vectors++;
      if ({tick_pulse, tick_count} !== {1'b1, 16'h0000}) begin
         miscompares++;
         $display("FAIL wrap_tick: got pulse=%b cnt=%h want 1 0000", tick_pulse, tick_count);
      end
      interrupt_i = 1'b1;
      step();
      vectors++;
      if ({CYC_O, tick_pulse} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_restart: got cyc=%b pulse=%b want 1 0", CYC_O, tick_pulse);
      end
      $display("wrap: cnt=%h, next cycle started cyc=%b", tick_count, CYC_O);
   endtask

   task automatic test_async_reset();
      // Still in REQ from the previous task; pull reset between clock edges.
      #2;
      RST_N_I = 1'b0;
      #1;
      vectors++;
      if ({CYC_O, STB_O} !== 2'b00) begin
         miscompares++;
         $display("FAIL async_drop: got cyc=%b stb=%b want 0 0", CYC_O, STB_O);
      end
      vectors++;
      if ({ADR_O, WE_O, tick_count, tick_pulse, bus_error, timeout_o, attempts} !== 54'd0) begin
         miscompares++;
         $display("FAIL async_values: got adr=%h we=%b cnt=%h pulse=%b err=%b to=%b att=%0d want all 0",
                  ADR_O, WE_O, tick_count, tick_pulse, bus_error, timeout_o, attempts);
      end
      interrupt_i = 1'b0;
      step();
      RST_N_I = 1'b1;
      step();
      interrupt_i = 1'b1;
      step();
      vectors++;
      if ({CYC_O, attempts} !== {1'b1, 4'd1}) begin
         miscompares++;
         $display("FAIL post_reset_req: got cyc=%b att=%0d want 1 1", CYC_O, attempts);
      end
      RTY_I = 1'b1; interrupt_i = 1'b0;
      step();
      RTY_I = 1'b0;
      step();
      vectors++;
      if ({tick_pulse, tick_count, bus_error} !== {1'b1, 16'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL post_reset_tick: got pulse=%b cnt=%h err=%b want 1 0001 0", tick_pulse, tick_count, bus_error);
      end
      $display("async reset: cyc dropped, next service cnt=%h", tick_count);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_sticky();
      test_timeout();
      test_err_wins();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
